dot_acc_engine: RTL

Streaming dot-product accumulator and successor to the single-shot multiply-reduce array. It takes ARRAY_SIZE operand pairs per beat under a valid/ready handshake and supports signed or unsigned operands. It sums the products across a variable number of beats and emits one fully resolved accumulated result per transaction, using a registered output with backpressure. It sits between the operand fetch stream and the result writeback of the AI core datapath.

---
 rtl/dot_acc_pkg.sv | 33 +++
 rtl/dot_acc_tree.sv | 82 ++++++++
 rtl/dot_acc_engine.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dot_acc_pkg.sv
// Shared types and width helpers for the streaming dot-product accumulator.
// stage_t is sized from the default configuration.
package dot_acc_pkg;

    function automatic int acc_size(input int in_0, input int in_1, input int lanes, input int depth);
        return in_0 + in_1 + $clog2(lanes) + $clog2(depth);
    endfunction

    function automatic int cnt_size(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_IN_SIZE_0     = 4;
    localparam int DEF_IN_SIZE_1     = 8;
    localparam int DEF_ARRAY_SIZE    = 8;
    localparam int DEF_ACC_DEPTH_MAX = 16;
    localparam int DEF_ACC_SIZE      = acc_size(DEF_IN_SIZE_0, DEF_IN_SIZE_1, DEF_ARRAY_SIZE, DEF_ACC_DEPTH_MAX);
    localparam int DEF_CNT_SIZE      = cnt_size(DEF_ACC_DEPTH_MAX);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    typedef struct packed {
        logic                    valid;
        logic                    last;
        logic                    trunc;
        logic [DEF_CNT_SIZE-1:0] count;
        logic [DEF_ACC_SIZE-1:0] sum;
    } stage_t;

endpackage

// File: rtl/dot_acc_tree.sv
// Registered lane products (S1) feeding a balanced adder tree whose sum is registered in S2.
// Beat metadata travels alongside so the accumulator stage knows when a transaction closes.
module dot_acc_tree
    import dot_acc_pkg::*;
#(
    parameter int IN_SIZE_0  = DEF_IN_SIZE_0,
    parameter int IN_SIZE_1  = DEF_IN_SIZE_1,
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int ACC_SIZE   = DEF_ACC_SIZE,
    parameter int CNT_SIZE   = DEF_CNT_SIZE
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_stall,
    input  logic                                i_valid,
    input  logic                                i_last,
    input  logic                                i_trunc,
    input  logic [CNT_SIZE-1:0]                 i_count,
    input  logic                                i_signed,
    input  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] i_in_0,
    input  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] i_in_1,
    output stage_t                              o_s2
);

    logic [ACC_SIZE-1:0] w_prod [ARRAY_SIZE];
    logic [ACC_SIZE-1:0] r_prod [ARRAY_SIZE];
    logic                r_s1_valid;
    logic                r_s1_last;
    logic                r_s1_trunc;
    logic [CNT_SIZE-1:0] r_s1_count;
    logic [ACC_SIZE-1:0] w_tree_sum;
    stage_t              r_s2;

    // Extending both operands to the full result width lets one modular multiply serve both modes.
    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        logic [ACC_SIZE-1:0] w_ext_0;
        logic [ACC_SIZE-1:0] w_ext_1;
        assign w_ext_0   = {{(ACC_SIZE-IN_SIZE_0){i_signed & i_in_0[g][IN_SIZE_0-1]}}, i_in_0[g]};
        assign w_ext_1   = {{(ACC_SIZE-IN_SIZE_1){i_signed & i_in_1[g][IN_SIZE_1-1]}}, i_in_1[g]};
        assign w_prod[g] = w_ext_0 * w_ext_1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_trunc <= 1'b0;
            r_s1_count <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) r_prod[i] <= '0;
        end else if (!i_stall) begin
            r_s1_valid <= i_valid;
            r_s1_last  <= i_last;
            r_s1_trunc <= i_trunc;
            r_s1_count <= i_count;
            for (int i = 0; i < ARRAY_SIZE; i++) r_prod[i] <= w_prod[i];
        end
    end

    // Heap-indexed tree: leaves at ARRAY_SIZE..2*ARRAY_SIZE-1, root at 1; valid for any lane count.
    always_comb begin : tree
        logic [ACC_SIZE-1:0] node [1:2*ARRAY_SIZE-1];
        for (int i = 1; i < 2*ARRAY_SIZE; i++) node[i] = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) node[ARRAY_SIZE+i] = r_prod[i];
        for (int i = ARRAY_SIZE-1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
        w_tree_sum = node[1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2 <= '0;
        end else if (!i_stall) begin
            r_s2.valid <= r_s1_valid;
            r_s2.last  <= r_s1_last;
            r_s2.trunc <= r_s1_trunc;
            r_s2.count <= r_s1_count;
            r_s2.sum   <= w_tree_sum;
        end
    end

    assign o_s2 = r_s2;

endmodule

// File: rtl/dot_acc_engine.sv
// Streaming dot-product accumulator: handshake, transaction FSM, beat counter, accumulator
// and backpressured result register around the product/adder-tree pipeline.
//
//   state | meaning
//   IDLE  | next accepted beat opens a transaction and samples the mode
//   ACCUM | transaction open, at least one non-closing beat accepted
module dot_acc_engine
    import dot_acc_pkg::*;
#(
    parameter int  IN_SIZE_0     = DEF_IN_SIZE_0,
    parameter int  IN_SIZE_1     = DEF_IN_SIZE_1,
    parameter int  ARRAY_SIZE    = DEF_ARRAY_SIZE,
    parameter int  ACC_DEPTH_MAX = DEF_ACC_DEPTH_MAX,
    localparam int ACC_SIZE      = acc_size(IN_SIZE_0, IN_SIZE_1, ARRAY_SIZE, ACC_DEPTH_MAX),
    localparam int CNT_SIZE      = cnt_size(ACC_DEPTH_MAX)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] in_0_i,
    input  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] in_1_i,
    input  logic                                 in_last_i,
    input  logic                                 signed_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [ACC_SIZE-1:0]                  out_data_o,
    output logic [CNT_SIZE-1:0]                  out_count_o,
    output logic                                 out_trunc_o
);

    logic                w_stall;
    logic                w_accept;
    logic [CNT_SIZE-1:0] w_beat_cnt;
    logic                w_at_depth;
    logic                w_close;
    logic                w_trunc;
    logic                w_mode;
    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_SIZE-1:0] r_cnt;
    logic                r_mode;
    stage_t              w_s2;
    logic [ACC_SIZE-1:0] r_acc;
    logic [ACC_SIZE-1:0] w_acc_sum;
    logic                r_out_valid;
    logic [ACC_SIZE-1:0] r_out_data;
    logic [CNT_SIZE-1:0] r_out_count;
    logic                r_out_trunc;

    assign w_stall    = r_out_valid & ~out_ready_i;
    assign in_ready_o = ~w_stall;
    assign w_accept   = in_valid_i & ~w_stall;
    assign w_beat_cnt = r_cnt + CNT_SIZE'(1);
    assign w_at_depth = (w_beat_cnt == CNT_SIZE'(ACC_DEPTH_MAX));
    assign w_close    = in_last_i | w_at_depth;
    assign w_trunc    = ~in_last_i & w_at_depth;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                IDLE:    if (!w_close) w_state_nxt = ACCUM;
                ACCUM:   if (w_close)  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_mode = r_mode;
        if (r_state == IDLE) w_mode = signed_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= w_close ? '0 : w_beat_cnt;
            r_mode <= w_mode;
        end
    end

    dot_acc_tree #(
        .IN_SIZE_0  (IN_SIZE_0),
        .IN_SIZE_1  (IN_SIZE_1),
        .ARRAY_SIZE (ARRAY_SIZE),
        .ACC_SIZE   (ACC_SIZE),
        .CNT_SIZE   (CNT_SIZE)
    ) u_tree (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_stall  (w_stall),
        .i_valid  (w_accept),
        .i_last   (w_close),
        .i_trunc  (w_trunc),
        .i_count  (w_beat_cnt),
        .i_signed (w_mode),
        .i_in_0   (in_0_i),
        .i_in_1   (in_1_i),
        .o_s2     (w_s2)
    );

    assign w_acc_sum = r_acc + w_s2.sum;

    // A closing beat overwrites the output even while the old result is being consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_trunc <= 1'b0;
        end else if (!w_stall) begin
            if (w_s2.valid && w_s2.last) begin
                r_out_data  <= w_acc_sum;
                r_out_count <= w_s2.count;
                r_out_trunc <= w_s2.trunc;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
            end else begin
                if (w_s2.valid) r_acc <= w_acc_sum;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_count_o = r_out_count;
    assign out_trunc_o = r_out_trunc;

endmodule
